// File: rtl/systolic_array_writeback.sv
// Streams a snapshotted 8x8 result tile to memory as 16 half-row beats.
// A stride under 8 would overlap rows, so that request is refused and reported through done/error.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif

// state  | meaning
// IDLE   | waiting for start; tile/base/stride captured on an accepted start
// WRITE  | presenting beat (row = r_beat[3:1], half = r_beat[0]) until mem_ready
// FINISH | one-cycle done pulse; error set if the request was refused
module systolic_array_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int BANDWIDTH  = 4,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DIM_WIDTH  = `DIM_WIDTH
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [7:0][7:0][DATA_WIDTH-1:0]      Out,
   input  logic [ADDR_WIDTH-1:0]                base_C,
   input  logic [DIM_WIDTH-1:0]                 dim_col_C,
   input  logic                                 mem_ready,
   output logic                                 write,
   output logic [ADDR_WIDTH-1:0]                write_addr,
   output logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] writedata,
   output logic                                 done,
   output logic                                 error
);

   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

   state_t                          r_state;
   state_t                          w_next;
   logic [7:0][7:0][DATA_WIDTH-1:0] r_tile;
   logic [DIM_WIDTH-1:0]            r_dim;
   logic [ADDR_WIDTH-1:0]           r_row_addr;
   logic [3:0]                      r_beat;
   logic                            r_err;
   logic                            w_go;
   logic                            w_reject;
   logic                            w_accept;
   logic                            w_last;

   assign w_go     = (r_state == IDLE) && start && (dim_col_C >= DIM_WIDTH'(8));
   assign w_reject = (r_state == IDLE) && start && (dim_col_C <  DIM_WIDTH'(8));
   assign w_accept = (r_state == WRITE) && mem_ready;
   assign w_last   = w_accept && (r_beat == 4'd15);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_go)          w_next = WRITE;
            else if (w_reject) w_next = FINISH;
         end
         WRITE:   if (w_last) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Row base is accumulated by the stride after each completed second half.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_beat     <= 4'd0;
         r_row_addr <= '0;
         r_err      <= 1'b0;
      end else if (w_go) begin
         r_beat     <= 4'd0;
         r_row_addr <= base_C;
         r_err      <= 1'b0;
      end else if (w_reject) begin
         r_beat     <= 4'd0;
         r_err      <= 1'b1;
      end else if (w_accept) begin
         r_beat <= r_beat + 4'd1;
         if (r_beat[0]) r_row_addr <= r_row_addr + ADDR_WIDTH'(r_dim);
      end
   end

   // Snapshot storage carries no reset; it is always reloaded before use.
   always_ff @(posedge clock) begin
      if (w_go) begin
         r_tile <= Out;
         r_dim  <= dim_col_C;
      end
   end

   always_comb begin
      write      = 1'b0;
      write_addr = '0;
      writedata  = '0;
      done       = (r_state == FINISH);
      error      = (r_state == FINISH) && r_err;
      if (r_state == WRITE) begin
         write      = 1'b1;
         write_addr = r_row_addr + ADDR_WIDTH'({r_beat[0], 2'b00});
         for (int k = 0; k < BANDWIDTH; k++) begin
            writedata[k] = r_tile[r_beat[3:1]][3'({r_beat[0], 2'b00}) + 3'(k)];
         end
      end
   end

endmodule
